adc_hyst_digitizer: RTL
=======================

# adc_hyst_digitizer

Multi-channel ADC threshold digitizer with hysteresis and sample-count debouncing. Takes a time-multiplexed stream of ADC samples (one channel per valid beat), converts each channel to a clean 1-bit logic level using separate high/low thresholds, and filters the result with a per-channel consecutive-sample debounce. It sits between the ADC interface and the game-logic inputs, and provides registered levels plus single-cycle rise/fall pulses per channel.

## Interface
- CH, 4: number of channels (1..16).
- DW, 12: ADC sample width.
- TH_HIGH, 1884: a sample strictly above this value is classified high (2.3 V at 5 V full scale).
- TH_LOW, 819: a sample strictly below this value is classified low (1.0 V). Must satisfy TH_LOW < TH_HIGH.
- DEB, 4: number of consecutive qualifying samples needed to change a channel's output (1..255).
- CHW, $clog2(CH) (minimum 1): width of the channel index.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sample_valid  in  1  qualifies sample_ch/adc_data for one cycle.
- sample_ch  in  CHW  channel index of the current sample.
- adc_data  in  DW  unsigned ADC code.
- sig_out  out  CH  debounced logic level per channel.
- rise  out  CH  one-cycle pulse when sig_out[i] goes 0→1.
- fall  out  CH  one-cycle pulse when sig_out[i] goes 1→0.
- ch_err  out  1  one-cycle pulse when a valid sample carries sample_ch >= CH.

## Operation
- Classification is evaluated only for the addressed channel i, and only when sample_valid=1:
  - adc_data > TH_HIGH gives candidate 1.
  - adc_data < TH_LOW gives candidate 0.
  - Any other value (including exactly TH_HIGH or exactly TH_LOW) gives candidate = sig_out[i]; this is the hysteresis hold.
- Each channel has a debounce counter cnt[i] of width $clog2(DEB+1).
  - If candidate == sig_out[i]: cnt[i] is cleared to 0.
  - If candidate != sig_out[i] and cnt[i]+1 == DEB: sig_out[i] is inverted, cnt[i] is cleared, and rise[i] or fall[i] is asserted.
  - Otherwise cnt[i] increments by 1.
- With DEB=1, the output flips on the first qualifying sample.
- A channel that receives no valid sample holds its counter and output. Samples addressed to other channels do not reset it, so "consecutive" means consecutive samples of that same channel.
- When sample_ch >= CH: no channel state changes, and ch_err pulses.
- When sample_valid=0: no state changes.

## Timing
- Reset values: sig_out=0, rise=0, fall=0, ch_err=0, all cnt=0. Reset takes effect immediately (asynchronous) and also aborts any in-progress debounce count.
- Latency: a qualifying sample with sample_valid high in cycle N updates sig_out at the rising edge ending cycle N. The new level is visible in cycle N+1, and rise/fall is high for exactly cycle N+1.
- rise/fall/ch_err are registered and deassert the following cycle unless re-triggered.
- At most one channel changes per cycle, so rise|fall is one-hot or zero.
- Back-to-back valid samples (sample_valid held high every cycle) are fully supported; there is no backpressure.
- All outputs are driven from flops; there is no combinational path from input to output.

## Test plan
- Reset and hold: rst low, then release with no samples → sig_out=0 and rise/fall/ch_err=0 for 20 cycles.
- Debounce rise, DEB=4, ch 2:
  - Four consecutive samples of 3000 → sig_out[2]=1 one cycle after the 4th sample; rise=4'b0100 for exactly one cycle.
  - Only three samples, then a 500 → no change, counter cleared.
- Hysteresis band, ch 0 high:
  - Samples 1884, 1200, 819 repeated 10× → sig_out[0] stays 1, no fall.
  - Then four samples of 818 → sig_out[0]=0 and fall[0] pulses.
- Interleaving: alternate ch 1=4000 and ch 3=100 (eight valid beats) → sig_out[1]=1 after ch 1's 4th sample; sig_out[3] stays 0; counters are independent.
- Invalid channel (CH=3, CHW=2): valid sample with sample_ch=3, data=4095 → ch_err pulses one cycle; sig_out unchanged.
- Reset mid-count: three samples of 3000 on ch 1, assert rst, release, then one more sample of 3000 → sig_out[1] still 0, because the count restarts from 0.

Source files
------------

// File: rtl/adc_hyst_digitizer.sv
// Multi-channel ADC threshold digitizer: per-channel hysteresis classification
// followed by a consecutive-sample debounce, with registered level and edge pulses.
module adc_hyst_digitizer #(
  parameter int CH      = 4,
  parameter int DW      = 12,
  parameter int TH_HIGH = 1884,
  parameter int TH_LOW  = 819,
  parameter int DEB     = 4,
  parameter int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sample_valid,
  input  logic [CHW-1:0] sample_ch,
  input  logic [DW-1:0]  adc_data,
  output logic [CH-1:0]  sig_out,
  output logic [CH-1:0]  rise,
  output logic [CH-1:0]  fall,
  output logic           ch_err
);

  localparam int CNTW = $clog2(DEB + 1);
  localparam logic [DW-1:0]   TH_HIGH_C = DW'(TH_HIGH);
  localparam logic [DW-1:0]   TH_LOW_C  = DW'(TH_LOW);
  localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEB - 1);
  localparam logic [CHW:0]    CH_LIM    = (CHW + 1)'(CH);

  // Handshake: sample_valid is a single-cycle qualifier with no ready; every
  // cycle with sample_valid high is consumed, so back-to-back beats are legal.

  logic [CNTW-1:0] cnt_q [CH];
  logic [CNTW-1:0] cnt_d [CH];
  logic [CH-1:0]   sig_d, rise_d, fall_d;
  logic            err_d;
  logic            in_range, above, below, cand;

  assign in_range = ({1'b0, sample_ch} < CH_LIM);
  assign above    = (adc_data > TH_HIGH_C);
  assign below    = (adc_data < TH_LOW_C);

  always_comb begin
    sig_d  = sig_out;
    rise_d = '0;
    fall_d = '0;
    err_d  = 1'b0;
    cand   = 1'b0;
    for (int i = 0; i < CH; i++) cnt_d[i] = cnt_q[i];
    if (sample_valid) begin
      err_d = ~in_range;
      for (int i = 0; i < CH; i++) begin
        if (in_range && sample_ch == CHW'(i)) begin
          // Values inside the band, including both thresholds, hold the level.
          cand = above ? 1'b1 : (below ? 1'b0 : sig_out[i]);
          if (cand == sig_out[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            sig_d[i]  = ~sig_out[i];
            rise_d[i] = ~sig_out[i];
            fall_d[i] = sig_out[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNTW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_out <= '0;
      rise    <= '0;
      fall    <= '0;
      ch_err  <= 1'b0;
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      sig_out <= sig_d;
      rise    <= rise_d;
      fall    <= fall_d;
      ch_err  <= err_d;
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
